// File: rtl/cdb_pkg.sv
// Shared CDB types and constants for the result-broadcast path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cdb_pkg;

    localparam int CDB_N_REQ  = 4;
    localparam int CDB_TAG_W  = 4;
    localparam int CDB_DATA_W = 32;
    localparam int CDB_ID_W   = 32;

    // Functional-unit port indices on the arbiter.
    localparam int FU_ALU = 0;
    localparam int FU_MUL = 1;
    localparam int FU_DIV = 2;
    localparam int FU_LSU = 3;

    // One completed result as carried on the CDB.
    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] wdata;
        logic [CDB_ID_W-1:0]   inst_id;
    } cdb_pkt_t;

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: picks the first asserted req starting at an internal pointer.
// Latency: grant is combinational from req; pointer updates at the clock edge.
// Backpressure: pointer only advances when adv=1 (grant actually consumed).
//
// Ports: clk/rst (sync, active-high), req[N] requests, adv consume strobe,
//        gnt[N] one-hot (or zero) grant, gnt_idx index of the granted requester.
module rr_arb
    import cdb_pkg::*;
#(
    parameter int N     = CDB_N_REQ,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             adv,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] idx_sel;
    logic             found;
    int               idx;

    // Search ptr, ptr+1, ... wrapping at N; the first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        idx_sel = '0;
        for (int k = 0; k < N; k++) begin
            idx     = (int'(ptr_q) + k) % N;
            idx_sel = IDX_W'(idx);
            if (!found && req[idx_sel]) begin
                found        = 1'b1;
                gnt[idx_sel] = 1'b1;
                gnt_idx      = idx_sel;
            end
        end
    end

    // The granted requester becomes lowest priority next time.
    always_comb begin
        ptr_d = ptr_q;
        if (adv) begin
            ptr_d = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cdb_arb.sv
// Shares the common data bus among N_REQ functional units via one-entry holding buffers.
// Latency: accepted at edge ending cycle t -> earliest CDB write in cycle t+1.
// Backpressure: req_rdy drops while a port's buffer waits for grant; a granted buffer reloads same cycle.
//
// Ports: clk/rst (sync, active-high), flush drops all buffered results,
//        req_vld/req_rdy/req_tag/req_wdata/req_inst_id per-FU result handshake,
//        cdb_wr/cdb_tag/cdb_wdata/cdb_inst_id broadcast, cdb_src granted FU index.
module cdb_arb
    import cdb_pkg::*;
#(
    parameter int N_REQ = CDB_N_REQ,
    parameter int TAG_W = CDB_TAG_W,
    parameter int ID_W  = CDB_ID_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [N_REQ-1:0]                  req_vld,
    output logic [N_REQ-1:0]                  req_rdy,
    input  logic [N_REQ-1:0][TAG_W-1:0]       req_tag,
    input  logic [N_REQ-1:0][31:0]            req_wdata,
    input  logic [N_REQ-1:0][ID_W-1:0]        req_inst_id,
    output logic                              cdb_wr,
    output logic [TAG_W-1:0]                  cdb_tag,
    output logic [31:0]                       cdb_wdata,
    output logic [ID_W-1:0]                   cdb_inst_id,
    output logic [$clog2(N_REQ)-1:0]          cdb_src
);

    localparam int SRC_W = $clog2(N_REQ);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      wdata;
        logic [ID_W-1:0]  inst_id;
    } pkt_t;

    logic [N_REQ-1:0]        buf_vld_q;
    logic [N_REQ-1:0]        buf_vld_d;
    pkt_t [N_REQ-1:0]        buf_q;
    pkt_t [N_REQ-1:0]        buf_d;
    logic [N_REQ-1:0]        grant;
    logic [SRC_W-1:0]        gnt_idx;
    pkt_t                    sel;

    // Arbitration looks only at buffers, so req_* never reaches cdb_* combinationally.
    rr_arb #(
        .N     (N_REQ),
        .IDX_W (SRC_W)
    ) u_rr_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (buf_vld_q),
        .adv     (cdb_wr),
        .gnt     (grant),
        .gnt_idx (gnt_idx)
    );

    // A buffer being granted this cycle is free at the edge, so it can accept again.
    assign req_rdy = (rst || flush) ? '0 : (~buf_vld_q | grant);

    // Flush and reset suppress the broadcast; the pointer then holds because adv=0.
    assign cdb_wr = (|grant) && !flush && !rst;

    always_comb begin
        buf_vld_d = buf_vld_q;
        buf_d     = buf_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (flush) begin
                buf_vld_d[i] = 1'b0;
            end else if (req_vld[i] && req_rdy[i]) begin
                buf_vld_d[i]     = 1'b1;
                buf_d[i].tag     = req_tag[i];
                buf_d[i].wdata   = req_wdata[i];
                buf_d[i].inst_id = req_inst_id[i];
            end else if (grant[i] && cdb_wr) begin
                buf_vld_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_vld_q <= '0;
        end else begin
            buf_vld_q <= buf_vld_d;
        end
    end

    // Payload needs no reset: it is qualified by buf_vld_q everywhere.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign sel         = buf_q[gnt_idx];
    assign cdb_tag     = cdb_wr ? sel.tag     : '0;
    assign cdb_wdata   = cdb_wr ? sel.wdata   : '0;
    assign cdb_inst_id = cdb_wr ? sel.inst_id : '0;
    assign cdb_src     = cdb_wr ? gnt_idx     : '0;

endmodule

// File: tb/tb_cdb_arb.sv
// Self-checking bench for cdb_arb: directed scenarios plus a randomized run against a reference model.
// Latency: n/a.
// Backpressure: stimulus holds payload stable while req_vld=1 and req_rdy=0.
module tb_cdb_arb;
    import cdb_pkg::*;

    localparam int N = CDB_N_REQ;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          flush;
    logic [N-1:0]                  req_vld;
    logic [N-1:0]                  req_rdy;
    logic [N-1:0][CDB_TAG_W-1:0]   req_tag;
    logic [N-1:0][31:0]            req_wdata;
    logic [N-1:0][CDB_ID_W-1:0]    req_inst_id;
    logic                          cdb_wr;
    logic [CDB_TAG_W-1:0]          cdb_tag;
    logic [31:0]                   cdb_wdata;
    logic [CDB_ID_W-1:0]           cdb_inst_id;
    logic [1:0]                    cdb_src;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cdb_arb #(.N_REQ(N), .TAG_W(CDB_TAG_W), .ID_W(CDB_ID_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_vld     (req_vld),
        .req_rdy     (req_rdy),
        .req_tag     (req_tag),
        .req_wdata   (req_wdata),
        .req_inst_id (req_inst_id),
        .cdb_wr      (cdb_wr),
        .cdb_tag     (cdb_tag),
        .cdb_wdata   (cdb_wdata),
        .cdb_inst_id (cdb_inst_id),
        .cdb_src     (cdb_src)
    );

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_vld     = '0;
        req_tag     = '0;
        req_wdata   = '0;
        req_inst_id = '0;
        flush       = 1'b0;
    endtask

    task automatic drive(input int p, input logic [3:0] tag, input logic [31:0] d, input logic [31:0] id);
        req_vld[p]     = 1'b1;
        req_tag[p]     = tag;
        req_wdata[p]   = d;
        req_inst_id[p] = id;
    endtask

    // Leaves the bench in cycle 0 after reset, inputs idle.
    task automatic do_reset();
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        settle();
        n_tests++;
        if (req_rdy !== 4'b0000) begin
            n_fail++; $display("FAIL reset_rdy: got %b want 0000", req_rdy);
        end
        n_tests++;
        if ({cdb_wr, cdb_tag, cdb_wdata, cdb_inst_id, cdb_src} !== '0) begin
            n_fail++; $display("FAIL reset_cdb: wr=%b tag=%h data=%h id=%h src=%0d want all 0",
                               cdb_wr, cdb_tag, cdb_wdata, cdb_inst_id, cdb_src);
        end
        next_cycle();
        rst = 1'b0;
        settle();
        n_tests++;
        if (req_rdy !== 4'b1111 || cdb_wr !== 1'b0) begin
            n_fail++; $display("FAIL post_reset: rdy=%b wr=%b want rdy=1111 wr=0", req_rdy, cdb_wr);
        end
    endtask

    task automatic test_single();
        do_reset();
        drive(FU_ALU, 4'd3, 32'hDEAD_BEEF, 32'h0000_0011);
        settle();
        n_tests++;
        if (cdb_wr !== 1'b0) begin
            n_fail++; $display("FAIL single_c0: wr=%b want 0", cdb_wr);
        end
        next_cycle();
        idle_inputs();
        settle();
        n_tests++;
        if ({cdb_wr, cdb_tag, cdb_wdata, cdb_inst_id, cdb_src} !== {1'b1, 4'd3, 32'hDEAD_BEEF, 32'h11, 2'd0}) begin
            n_fail++; $display("FAIL single_c1: wr=%b tag=%0d data=%h id=%h src=%0d want 1/3/deadbeef/11/0",
                               cdb_wr, cdb_tag, cdb_wdata, cdb_inst_id, cdb_src);
        end
        for (int c = 2; c < 5; c++) begin
            next_cycle();
            settle();
            n_tests++;
            if (cdb_wr !== 1'b0) begin
                n_fail++; $display("FAIL single_after c%0d: wr=%b want 0", c, cdb_wr);
            end
        end
    endtask

    task automatic test_all_four();
        logic [3:0] exp_rdy;
        do_reset();
        for (int p = 0; p < N; p++) drive(p, 4'(p + 1), 32'hA000_0000 + p, 100 + p);
        settle();
        n_tests++;
        if (req_rdy !== 4'b1111 || cdb_wr !== 1'b0) begin
            n_fail++; $display("FAIL all4_c0: rdy=%b wr=%b want 1111/0", req_rdy, cdb_wr);
        end
        next_cycle();
        idle_inputs();
        for (int k = 1; k <= N; k++) begin
            settle();
            exp_rdy = 4'((1 << k) - 1);
            n_tests++;
            if (cdb_wr !== 1'b1 || cdb_tag !== 4'(k) || cdb_src !== 2'(k - 1) || cdb_wdata !== 32'hA000_0000 + k - 1) begin
                n_fail++; $display("FAIL all4_order c%0d: wr=%b tag=%0d src=%0d data=%h want 1/%0d/%0d",
                                   k, cdb_wr, cdb_tag, cdb_src, cdb_wdata, k, k - 1);
            end
            n_tests++;
            if (req_rdy !== exp_rdy) begin
                n_fail++; $display("FAIL all4_rdy c%0d: got %b want %b", k, req_rdy, exp_rdy);
            end
            next_cycle();
        end
        settle();
        n_tests++;
        if (cdb_wr !== 1'b0) begin
            n_fail++; $display("FAIL all4_done: wr=%b want 0", cdb_wr);
        end
    endtask

    task automatic test_saturation();
        int cnt [N];
        for (int p = 0; p < N; p++) cnt[p] = 0;
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            if (c < 40) begin
                for (int p = 0; p < N; p++) drive(p, 4'(p + 1), {8'(p), 24'(c)}, c);
            end else begin
                idle_inputs();
            end
            settle();
            if (c > 0) begin
                n_tests++;
                if (cdb_wr !== 1'b1 || cdb_src !== 2'((c - 1) % N) || cdb_tag !== 4'(((c - 1) % N) + 1)) begin
                    n_fail++; $display("FAIL sat_seq c%0d: wr=%b src=%0d tag=%0d want src %0d", c, cdb_wr, cdb_src, cdb_tag, (c - 1) % N);
                end
                if (cdb_wr === 1'b1) cnt[cdb_src]++;
            end
            next_cycle();
        end
        idle_inputs();
        for (int p = 0; p < N; p++) begin
            n_tests++;
            if (cnt[p] != 10) begin
                n_fail++; $display("FAIL sat_count port%0d: got %0d want 10", p, cnt[p]);
            end
        end
        repeat (N) next_cycle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            idle_inputs();
            if (c < 3) drive(FU_MUL, 4'(5 + c), 32'h5000 + c, 32'h700 + c);
            settle();
            if (c < 3) begin
                n_tests++;
                if (req_rdy[FU_MUL] !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_rdy c%0d: got %b want 1", c, req_rdy[FU_MUL]);
                end
            end
            if (c >= 1 && c <= 3) begin
                n_tests++;
                if (cdb_wr !== 1'b1 || cdb_tag !== 4'(4 + c) || cdb_src !== 2'(FU_MUL) || cdb_wdata !== 32'h5000 + c - 1) begin
                    n_fail++; $display("FAIL b2b_cdb c%0d: wr=%b tag=%0d src=%0d data=%h want tag %0d", c, cdb_wr, cdb_tag, cdb_src, cdb_wdata, 4 + c);
                end
            end
            if (c == 4) begin
                n_tests++;
                if (cdb_wr !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_done: wr=%b want 0", cdb_wr);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(FU_ALU, 4'd1, 32'h1111, 32'h1);
        drive(FU_DIV, 4'd9, 32'h9999, 32'h9);
        settle();
        next_cycle();
        idle_inputs();
        flush = 1'b1;
        settle();
        n_tests++;
        if (cdb_wr !== 1'b0 || req_rdy !== 4'b0000) begin
            n_fail++; $display("FAIL flush_cycle: wr=%b rdy=%b want 0/0000", cdb_wr, req_rdy);
        end
        next_cycle();
        flush = 1'b0;
        drive(FU_DIV, 4'd4, 32'h4444, 32'h4);
        settle();
        n_tests++;
        if (cdb_wr !== 1'b0 || req_rdy !== 4'b1111) begin
            n_fail++; $display("FAIL flush_after: wr=%b rdy=%b want 0/1111", cdb_wr, req_rdy);
        end
        next_cycle();
        idle_inputs();
        settle();
        n_tests++;
        if (cdb_wr !== 1'b1 || cdb_tag !== 4'd4 || cdb_src !== 2'(FU_DIV) || cdb_wdata !== 32'h4444) begin
            n_fail++; $display("FAIL flush_new: wr=%b tag=%0d src=%0d data=%h want 1/4/2/4444", cdb_wr, cdb_tag, cdb_src, cdb_wdata);
        end
        next_cycle();
        settle();
        n_tests++;
        if (cdb_wr !== 1'b0) begin
            n_fail++; $display("FAIL flush_drained: wr=%b want 0", cdb_wr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(FU_ALU, 4'd1, 32'h1, 32'h1);
        drive(FU_MUL, 4'd2, 32'h2, 32'h2);
        drive(FU_DIV, 4'd3, 32'h3, 32'h3);
        settle();
        next_cycle();
        idle_inputs();
        drive(FU_LSU, 4'd4, 32'h4, 32'h4);
        settle();
        n_tests++;
        if (cdb_wr !== 1'b1 || cdb_tag !== 4'd1 || cdb_src !== 2'd0) begin
            n_fail++; $display("FAIL rmid_pre: wr=%b tag=%0d src=%0d want 1/1/0", cdb_wr, cdb_tag, cdb_src);
        end
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        settle();
        n_tests++;
        if (cdb_wr !== 1'b0 || req_rdy !== 4'b0000) begin
            n_fail++; $display("FAIL rmid_during: wr=%b rdy=%b want 0/0000", cdb_wr, req_rdy);
        end
        next_cycle();
        rst = 1'b0;
        drive(FU_LSU, 4'd5, 32'h55, 32'h5);
        drive(FU_ALU, 4'd6, 32'h66, 32'h6);
        settle();
        n_tests++;
        if (cdb_wr !== 1'b0 || req_rdy !== 4'b1111) begin
            n_fail++; $display("FAIL rmid_after: wr=%b rdy=%b want 0/1111", cdb_wr, req_rdy);
        end
        next_cycle();
        idle_inputs();
        settle();
        n_tests++;
        if (cdb_wr !== 1'b1 || cdb_src !== 2'd0 || cdb_tag !== 4'd6) begin
            n_fail++; $display("FAIL rmid_first: wr=%b src=%0d tag=%0d want 1/0/6", cdb_wr, cdb_src, cdb_tag);
        end
        next_cycle();
        settle();
        n_tests++;
        if (cdb_wr !== 1'b1 || cdb_src !== 2'd3 || cdb_tag !== 4'd5) begin
            n_fail++; $display("FAIL rmid_second: wr=%b src=%0d tag=%0d want 1/3/5", cdb_wr, cdb_src, cdb_tag);
        end
        next_cycle();
        settle();
        n_tests++;
        if (cdb_wr !== 1'b0) begin
            n_fail++; $display("FAIL rmid_done: wr=%b want 0", cdb_wr);
        end
    endtask

    // Model: each port owns at most one pending result; service order rotates from
    // the port after the last one served.
    task automatic test_random();
        bit         m_vld [N];
        cdb_pkt_t   m_pkt [N];
        bit         hold  [N];
        int         m_ptr;
        int         g;
        bit         found;
        bit         exp_wr;
        logic [3:0] exp_rdy;
        cdb_pkt_t   exp_pkt;
        logic [74:0] got_v, exp_v;
        int n_acc, n_obs, n_drop, n_left;
        int bad;
        n_acc = 0; n_obs = 0; n_drop = 0; bad = 0; m_ptr = 0;
        for (int p = 0; p < N; p++) begin m_vld[p] = 0; hold[p] = 0; end
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            flush = ($urandom_range(0, 19) == 0);
            for (int p = 0; p < N; p++) begin
                if (!hold[p]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        drive(p, 4'($urandom_range(1, 15)), $urandom, $urandom);
                    end else begin
                        req_vld[p] = 1'b0;
                    end
                end
            end
            found = 0; g = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && m_vld[(m_ptr + k) % N]) begin
                    found = 1; g = (m_ptr + k) % N;
                end
            end
            exp_wr = found && !flush;
            for (int p = 0; p < N; p++) exp_rdy[p] = !flush && (!m_vld[p] || (found && g == p));
            exp_pkt = exp_wr ? m_pkt[g] : '0;
            exp_v = {exp_wr, (exp_wr ? 2'(g) : 2'd0), exp_pkt.tag, exp_pkt.wdata, exp_pkt.inst_id, exp_rdy};
            settle();
            got_v = {cdb_wr, cdb_src, cdb_tag, cdb_wdata, cdb_inst_id, req_rdy};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                if (bad < 10) $display("FAIL rand_cyc%0d: got %h want %h", cyc, got_v, exp_v);
                bad++;
            end
            if (cdb_wr === 1'b1) begin
                n_obs++;
                n_tests++;
                if (cdb_tag === '0) begin
                    n_fail++; $display("FAIL rand_tag0 cyc%0d: broadcast tag 0", cyc);
                end
            end
            if (exp_wr) m_ptr = (g + 1) % N;
            for (int p = 0; p < N; p++) begin
                if (flush) begin
                    if (m_vld[p]) n_drop++;
                    m_vld[p] = 0;
                end else if (req_vld[p] && exp_rdy[p]) begin
                    m_vld[p] = 1;
                    m_pkt[p] = '{tag: req_tag[p], wdata: req_wdata[p], inst_id: req_inst_id[p]};
                    n_acc++;
                end else if (exp_wr && g == p) begin
                    m_vld[p] = 0;
                end
                hold[p] = req_vld[p] && !exp_rdy[p];
            end
            next_cycle();
        end
        n_left = 0;
        for (int p = 0; p < N; p++) if (m_vld[p]) n_left++;
        n_tests++;
        if (n_acc != n_obs + n_drop + n_left) begin
            n_fail++; $display("FAIL rand_conserve: accepted %0d, broadcast %0d + dropped %0d + pending %0d",
                               n_acc, n_obs, n_drop, n_left);
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_all_four();
        test_saturation();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
